// File: rtl/dmem_ctrl_pkg.sv
// dmem_ctrl_pkg: shared encodings and lane helpers for the data-memory sequencer.
//   - SIZE_B/H/W : request size encodings (2'b11 is illegal)
//   - dmem_state_e : sequencer FSM states
//   - DMEM_ERR : value of the response error flag for misaligned/illegal accesses
//   - is_misaligned / lane_shift / lane_mask : lane-index helpers
package dmem_ctrl_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    localparam logic DMEM_ERR = 1'b1;

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StAccess = 2'b01,
        StWrite  = 2'b10,
        StResp   = 2'b11
    } dmem_state_e;

    // Illegal size encodings are reported the same way as misalignment.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis;
        case (size)
            SIZE_B:  mis = 1'b0;
            SIZE_H:  mis = addr_lo[0];
            SIZE_W:  mis = |addr_lo;
            default: mis = 1'b1;
        endcase
        return mis;
    endfunction

    // Bit offset of the addressed lane inside the word. Halfwords only use lanes 0/2.
    function automatic logic [4:0] lane_shift(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [4:0] sh;
        case (size)
            SIZE_B:  sh = {addr_lo, 3'b000};
            SIZE_H:  sh = {addr_lo[1], 4'b0000};
            default: sh = 5'd0;
        endcase
        return sh;
    endfunction

    // Bit mask covering the addressed lane(s); word and illegal sizes cover everything.
    function automatic logic [31:0] lane_mask(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [31:0] m;
        case (size)
            SIZE_B:  m = 32'h0000_00ff << lane_shift(size, addr_lo);
            SIZE_H:  m = 32'h0000_ffff << lane_shift(size, addr_lo);
            default: m = 32'hffff_ffff;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: combinational lane steering for loads and read-modify-write stores.
// Ports:
//   word_i      : word read from RAM
//   addr_lo_i   : byte address bits [1:0]
//   size_i      : access size (SIZE_B/H/W)
//   unsigned_i  : 1 = zero-extend loads, 0 = sign-extend
//   wdata_i     : right-justified store data
//   load_data_o : addressed lane, extended to 32 bits
//   store_word_o: word_i with the addressed lane(s) replaced by wdata_i
module dmem_lane_align
    import dmem_ctrl_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_data_o,
    output logic [31:0] store_word_o
);

    logic [4:0]  shamt;
    logic [31:0] shifted;
    logic [31:0] mask;
    logic [31:0] wdata_pos;

    always_comb begin
        shamt   = lane_shift(size_i, addr_lo_i);
        shifted = word_i >> shamt;
        mask    = lane_mask(size_i, addr_lo_i);

        case (size_i)
            SIZE_B: begin
                load_data_o = unsigned_i ? {24'd0, shifted[7:0]}
                                         : {{24{shifted[7]}}, shifted[7:0]};
                wdata_pos   = {24'd0, wdata_i[7:0]} << shamt;
            end
            SIZE_H: begin
                load_data_o = unsigned_i ? {16'd0, shifted[15:0]}
                                         : {{16{shifted[15]}}, shifted[15:0]};
                wdata_pos   = {16'd0, wdata_i[15:0]} << shamt;
            end
            default: begin
                load_data_o = word_i;
                wdata_pos   = wdata_i;
            end
        endcase

        store_word_o = (word_i & ~mask) | (wdata_pos & mask);
    end

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: one-at-a-time load/store sequencer between the MEM stage and a word-only RAM.
// Sub-word stores are done as read-modify-write; loads are lane-aligned and extended.
// Ports:
//   i_Clk, i_reset          : clock, synchronous active-low reset
//   i_req_* / o_req_ready   : request channel (accepted only in IDLE)
//   o_rsp_* / i_rsp_ready   : response channel (rdata, err)
//   o_ram_we/w_addr/w_data  : RAM write port (word-aligned address)
//   o_ram_r_addr/i_ram_r_data : RAM read port, combinational read data
module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              i_Clk,
    input  logic              i_reset,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_we,
    input  logic [1:0]        i_req_size,
    input  logic              i_req_unsigned,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [DATA_W-1:0] i_req_wdata,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DATA_W-1:0] o_rsp_rdata,
    output logic              o_rsp_err,
    output logic              o_ram_we,
    output logic [ADDR_W-1:0] o_ram_w_addr,
    output logic [DATA_W-1:0] o_ram_w_data,
    output logic [ADDR_W-1:0] o_ram_r_addr,
    input  logic [DATA_W-1:0] i_ram_r_data
);

    dmem_state_e       state_q, state_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] wword_q, wword_d;

    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] store_word;

    dmem_lane_align u_lane_align (
        .word_i       (i_ram_r_data),
        .addr_lo_i    (addr_q[1:0]),
        .size_i       (size_q),
        .unsigned_i   (uns_q),
        .wdata_i      (wdata_q),
        .load_data_o  (load_data),
        .store_word_o (store_word)
    );

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        wword_d = wword_q;

        o_req_ready = (state_q == StIdle);
        o_rsp_valid = (state_q == StResp);
        o_ram_we    = (state_q == StWrite);

        case (state_q)
            StIdle: begin
                if (i_req_valid) begin
                    we_d    = i_req_we;
                    size_d  = i_req_size;
                    uns_d   = i_req_unsigned;
                    addr_d  = i_req_addr;
                    wdata_d = i_req_wdata;
                    // Stores and errors answer with zero data.
                    rdata_d = '0;
                    if (is_misaligned(i_req_size, i_req_addr[1:0])) begin
                        err_d   = DMEM_ERR;
                        state_d = StResp;
                    end else begin
                        err_d   = 1'b0;
                        state_d = StAccess;
                    end
                end
            end
            StAccess: begin
                if (we_q) begin
                    wword_d = store_word;
                    state_d = StWrite;
                end else begin
                    rdata_d = load_data;
                    state_d = StResp;
                end
            end
            StWrite: begin
                state_d = StResp;
            end
            StResp: begin
                if (i_rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Both RAM addresses come straight from the latched request; outside ACCESS the
    // read address simply holds it.
    assign o_ram_r_addr = {addr_q[ADDR_W-1:2], 2'b00};
    assign o_ram_w_addr = {addr_q[ADDR_W-1:2], 2'b00};
    assign o_ram_w_data = wword_q;
    assign o_rsp_rdata  = rdata_q;
    assign o_rsp_err    = err_q;

    always_ff @(posedge i_Clk) begin
        if (!i_reset) begin
            state_q <= StIdle;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            wword_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            wword_q <= wword_d;
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed-vector bench with response and RAM-write scoreboards for dmem_ctrl.
module tb_dmem_ctrl;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              i_Clk = 1'b0;
    logic              i_reset = 1'b0;
    logic              i_req_valid = 1'b0;
    logic              o_req_ready;
    logic              i_req_we = 1'b0;
    logic [1:0]        i_req_size = 2'b00;
    logic              i_req_unsigned = 1'b0;
    logic [ADDR_W-1:0] i_req_addr = '0;
    logic [DATA_W-1:0] i_req_wdata = '0;
    logic              o_rsp_valid;
    logic              i_rsp_ready = 1'b1;
    logic [DATA_W-1:0] o_rsp_rdata;
    logic              o_rsp_err;
    logic              o_ram_we;
    logic [ADDR_W-1:0] o_ram_w_addr;
    logic [DATA_W-1:0] o_ram_w_data;
    logic [ADDR_W-1:0] o_ram_r_addr;
    logic [DATA_W-1:0] i_ram_r_data;

    dmem_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .i_Clk          (i_Clk),
        .i_reset        (i_reset),
        .i_req_valid    (i_req_valid),
        .o_req_ready    (o_req_ready),
        .i_req_we       (i_req_we),
        .i_req_size     (i_req_size),
        .i_req_unsigned (i_req_unsigned),
        .i_req_addr     (i_req_addr),
        .i_req_wdata    (i_req_wdata),
        .o_rsp_valid    (o_rsp_valid),
        .i_rsp_ready    (i_rsp_ready),
        .o_rsp_rdata    (o_rsp_rdata),
        .o_rsp_err      (o_rsp_err),
        .o_ram_we       (o_ram_we),
        .o_ram_w_addr   (o_ram_w_addr),
        .o_ram_w_data   (o_ram_w_data),
        .o_ram_r_addr   (o_ram_r_addr),
        .i_ram_r_data   (i_ram_r_data)
    );

    always #5 i_Clk = ~i_Clk;

    // Word RAM model: combinational read, write on posedge.
    logic [31:0] mem [0:63];
    assign i_ram_r_data = mem[o_ram_r_addr[7:2]];
    always @(posedge i_Clk) begin
        if (o_ram_we) mem[o_ram_w_addr[7:2]] <= o_ram_w_data;
    end

    int unsigned cyc = 0;
    always @(posedge i_Clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int unsigned exp_lat;
        logic [31:0] exp_wword;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int unsigned lat;
        int unsigned acc;
    } rsp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    rsp_t rsp_q[$];
    wr_t  wr_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        n_checks++;
        n_fail++;
        $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
    endtask

    // Monitor: pops expected writes/responses whenever the DUT presents them.
    logic        seen_valid = 1'b0;
    int unsigned first_cyc  = 0;
    always @(negedge i_Clk) begin
        if (o_ram_we) begin
            if (wr_q.size() == 0) begin
                fail_now("unexpected_write", $sformatf("addr 0x%08h data 0x%08h, none expected",
                                                       o_ram_w_addr, o_ram_w_data));
            end else begin
                check("ram_w_addr", o_ram_w_addr, wr_q[0].addr);
                check("ram_w_data", o_ram_w_data, wr_q[0].data);
                void'(wr_q.pop_front());
            end
        end
        if (o_rsp_valid) begin
            if (rsp_q.size() == 0) begin
                fail_now("unexpected_rsp", $sformatf("rdata 0x%08h err %0b, none expected",
                                                     o_rsp_rdata, o_rsp_err));
            end else begin
                if (!seen_valid) begin
                    seen_valid = 1'b1;
                    first_cyc  = cyc;
                end
                check("rsp_rdata", o_rsp_rdata, rsp_q[0].rdata);
                check("rsp_err", 32'(o_rsp_err), 32'(rsp_q[0].err));
                check("req_ready_in_resp", 32'(o_req_ready), 32'd0);
                if (i_rsp_ready) begin
                    check("rsp_latency", first_cyc - rsp_q[0].acc, rsp_q[0].lat);
                    void'(rsp_q.pop_front());
                    seen_valid = 1'b0;
                end
            end
        end
    end

    function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] exp_rdata, input logic exp_err,
                                input int unsigned exp_lat, input logic [31:0] exp_wword);
        vec_t v;
        v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat;
        v.exp_wword = exp_wword;
        return v;
    endfunction

    task automatic issue(input vec_t v);
        int n = 0;
        rsp_t r;
        wr_t  w;
        @(negedge i_Clk);
        i_req_valid    = 1'b1;
        i_req_we       = v.we;
        i_req_size     = v.size;
        i_req_unsigned = v.uns;
        i_req_addr     = v.addr;
        i_req_wdata    = v.wdata;
        while (!o_req_ready && n < 20) begin
            @(negedge i_Clk);
            n++;
        end
        if (!o_req_ready) begin
            fail_now("req_ready_timeout", "request never accepted");
            i_req_valid = 1'b0;
            return;
        end
        r.rdata = v.exp_rdata; r.err = v.exp_err; r.lat = v.exp_lat; r.acc = cyc;
        rsp_q.push_back(r);
        if (v.we && !v.exp_err) begin
            w.addr = {v.addr[31:2], 2'b00};
            w.data = v.exp_wword;
            wr_q.push_back(w);
        end
        @(posedge i_Clk);
        #1;
        i_req_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while ((rsp_q.size() != 0 || wr_q.size() != 0) && n < 50) begin
            @(negedge i_Clk);
            n++;
        end
        if (rsp_q.size() != 0 || wr_q.size() != 0) begin
            fail_now("rsp_timeout", $sformatf("%0d responses, %0d writes outstanding",
                                              rsp_q.size(), wr_q.size()));
            rsp_q.delete();
            wr_q.delete();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 32'(o_req_ready), 32'd1);
        check({tag, "_rsp_valid"}, 32'(o_rsp_valid), 32'd0);
        check({tag, "_rsp_rdata"}, o_rsp_rdata, 32'd0);
        check({tag, "_rsp_err"},   32'(o_rsp_err), 32'd0);
        check({tag, "_ram_we"},    32'(o_ram_we), 32'd0);
        check({tag, "_ram_w_addr"}, o_ram_w_addr, 32'd0);
        check({tag, "_ram_w_data"}, o_ram_w_data, 32'd0);
        check({tag, "_ram_r_addr"}, o_ram_r_addr, 32'd0);
    endtask

    localparam logic [1:0] SB = 2'b00, SH = 2'b01, SW = 2'b10, SX = 2'b11;

    vec_t vecs[$];

    initial begin
        // we, size, uns, addr, wdata, exp_rdata, exp_err, lat, exp_wword
        vecs.push_back(mk(1, SW, 0, 32'h10, 32'hDEADBEEF, 32'h0,        0, 3, 32'hDEADBEEF));
        vecs.push_back(mk(0, SW, 0, 32'h10, 32'h0,        32'hDEADBEEF, 0, 2, 32'h0));
        vecs.push_back(mk(1, SW, 0, 32'h20, 32'h11223344, 32'h0,        0, 3, 32'h11223344));
        vecs.push_back(mk(1, SB, 0, 32'h22, 32'h123456AA, 32'h0,        0, 3, 32'h11AA3344));
        vecs.push_back(mk(0, SB, 0, 32'h22, 32'h0,        32'hFFFFFFAA, 0, 2, 32'h0));
        vecs.push_back(mk(0, SB, 1, 32'h22, 32'h0,        32'h000000AA, 0, 2, 32'h0));
        vecs.push_back(mk(0, SB, 0, 32'h23, 32'h0,        32'h00000011, 0, 2, 32'h0));
        vecs.push_back(mk(0, SB, 1, 32'h21, 32'h0,        32'h00000033, 0, 2, 32'h0));
        vecs.push_back(mk(1, SW, 0, 32'h30, 32'h11223344, 32'h0,        0, 3, 32'h11223344));
        vecs.push_back(mk(1, SH, 0, 32'h32, 32'hABCD8001, 32'h0,        0, 3, 32'h80013344));
        vecs.push_back(mk(0, SH, 0, 32'h32, 32'h0,        32'hFFFF8001, 0, 2, 32'h0));
        vecs.push_back(mk(0, SH, 1, 32'h30, 32'h0,        32'h00003344, 0, 2, 32'h0));
        vecs.push_back(mk(0, SH, 0, 32'h30, 32'h0,        32'h00003344, 0, 2, 32'h0));
        vecs.push_back(mk(0, SW, 0, 32'h41, 32'h0,        32'h0,        1, 1, 32'h0));
        vecs.push_back(mk(1, SH, 0, 32'h43, 32'hFFFF,     32'h0,        1, 1, 32'h0));
        vecs.push_back(mk(1, SX, 0, 32'h40, 32'h55555555, 32'h0,        1, 1, 32'h0));
        vecs.push_back(mk(0, SX, 1, 32'h40, 32'h0,        32'h0,        1, 1, 32'h0));

        i_reset = 1'b0;
        repeat (2) @(posedge i_Clk);
        @(negedge i_Clk);
        check_reset_outputs("por");
        i_reset = 1'b1;

        foreach (vecs[i]) begin
            issue(vecs[i]);
            wait_done();
        end

        // Backpressure: response held, new request ignored meanwhile.
        i_rsp_ready = 1'b0;
        issue(mk(0, SW, 0, 32'h20, 32'h0, 32'h11AA3344, 0, 2, 32'h0));
        i_req_valid    = 1'b1;
        i_req_we       = 1'b1;
        i_req_size     = SW;
        i_req_unsigned = 1'b0;
        i_req_addr     = 32'h24;
        i_req_wdata    = 32'h55AA55AA;
        repeat (7) @(negedge i_Clk);
        i_req_valid = 1'b0;
        i_rsp_ready = 1'b1;
        wait_done();
        @(posedge i_Clk);
        #1;
        check("bp_ready_after", 32'(o_req_ready), 32'd1);

        // Reset during ACCESS of a store: write must not happen.
        issue(mk(1, SW, 0, 32'h50, 32'hCAFEF00D, 32'h0, 0, 3, 32'hCAFEF00D));
        wait_done();
        @(negedge i_Clk);
        i_req_valid    = 1'b1;
        i_req_we       = 1'b1;
        i_req_size     = SW;
        i_req_addr     = 32'h50;
        i_req_wdata    = 32'h12345678;
        @(posedge i_Clk);
        #1;
        i_req_valid = 1'b0;
        @(negedge i_Clk);
        i_reset = 1'b0;
        @(negedge i_Clk);
        check_reset_outputs("mid");
        i_reset = 1'b1;
        repeat (3) @(negedge i_Clk);
        issue(mk(0, SW, 0, 32'h50, 32'h0, 32'hCAFEF00D, 0, 2, 32'h0));
        wait_done();
        issue(mk(1, SB, 0, 32'h51, 32'h77, 32'h0, 0, 3, 32'hCAFE770D));
        wait_done();

        repeat (3) @(negedge i_Clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
Sequencer between the MEM pipeline stage and the word-addressed data RAM. It accepts one load/store request at a time over a valid/ready handshake. Byte/halfword stores are done as read-modify-write because the RAM only writes whole words. Loads are aligned and sign/zero-extended, misaligned accesses are flagged, and the result is returned over a valid/ready response channel.

Parameters:
ADDR_W, 32, byte-address width; RAM word index is addr[ADDR_W-1:2]
DATA_W, 32, data width; fixed at 32 (4 byte lanes)

Ports:
i_Clk  input  1  clock; all state updates on posedge
i_reset  input  1  reset; synchronous, active-low (0 sampled at posedge resets the block)
i_req_valid  input  1  request present
o_req_ready  output  1  high only in IDLE
i_req_we  input  1  1=store, 0=load
i_req_size  input  2  00=byte, 01=half, 10=word, 11=illegal (treated as misaligned)
i_req_unsigned  input  1  loads: 1=zero-extend, 0=sign-extend
i_req_addr  input  ADDR_W  byte address
i_req_wdata  input  DATA_W  store data, right-justified
o_rsp_valid  output  1  response present
i_rsp_ready  input  1  consumer accepts response
o_rsp_rdata  output  DATA_W  extended load data; 0 for stores and errors
o_rsp_err  output  1  misaligned/illegal access
o_ram_we  output  1  RAM write enable
o_ram_w_addr  output  ADDR_W  RAM write byte address, low 2 bits forced 00
o_ram_w_data  output  DATA_W  merged write word
o_ram_r_addr  output  ADDR_W  RAM read byte address, low 2 bits forced 00
i_ram_r_data  input  DATA_W  RAM read word; combinational, same cycle as o_ram_r_addr

Behaviour:
- Reset (i_reset=0 at posedge): state IDLE; all latched request fields 0. Outputs after reset: o_req_ready=1, o_rsp_valid=0, o_rsp_rdata=0, o_rsp_err=0, o_ram_we=0, o_ram_w_addr=0, o_ram_w_data=0, o_ram_r_addr=0.
- States: IDLE, ACCESS, WRITE, RESP.
- IDLE: request accepted on i_req_valid & o_req_ready. All fields are latched. Misaligned means half with addr[0]=1, word with addr[1:0]!=0, or size=11.
  - Misaligned: go to RESP with err=1. No RAM access occurs.
  - Otherwise: go to ACCESS.
- ACCESS: o_ram_r_addr = latched addr with [1:0]=00. i_ram_r_data is registered this cycle.
  - Load: rdata = lane at addr[1:0] (byte lanes 0-3 or half lanes 0/2), extended per size/unsigned. Go to RESP.
  - Store: merged word = read word with the addressed lane(s) replaced by wdata[7:0] or [15:0]. A word store replaces the whole word. Go to WRITE.
- WRITE: o_ram_we=1 for exactly one cycle with the merged word. Go to RESP.
- RESP: o_rsp_valid=1. Data and err stay stable until i_rsp_ready. On the handshake, return to IDLE.
  - No new request is accepted in the same cycle; ready returns the next cycle.
- Latency, from accept edge T:
  - load: o_rsp_valid after T+2
  - store: o_ram_we in the cycle after T+1 edge, o_rsp_valid after T+3
  - error: o_rsp_valid after T+1
- o_ram_we is decoded from state==WRITE. o_ram_w_addr/o_ram_w_data are driven from latched values in all states. o_ram_r_addr holds the latched address outside ACCESS.
- Reset mid-operation:
  - A write whose WRITE-cycle posedge coincides with i_reset=0 still commits, because the RAM samples we on that edge.
  - No RAM write or response occurs after reset. Any pending response is dropped.
- Backpressure: the block can sit in RESP indefinitely with o_req_ready=0. i_req_* are ignored outside IDLE.

Decomposition:
- Shared package/defines entries: size encodings (SIZE_B/H/W), state encodings, DMEM_ERR constant, lane-index helpers.
- One combinational sub-module, dmem_lane_align.
  - Inputs: word, addr[1:0], size, unsigned, wdata.
  - Outputs: extended load data and merged store word.
  - The FSM, handshake and latches stay in dmem_ctrl.

Test Plan:
- Word store then load: sw 0xDEADBEEF @0x10, then lw @0x10 -> o_ram_we one cycle with w_addr=0x10, w_data=0xDEADBEEF; load rsp_rdata=0xDEADBEEF, err=0, rsp_valid 2 cycles after accept.
- Byte RMW: RAM[0x20]=0x11223344; sb 0xAA @0x22 -> w_data=0x11AA3344; lb @0x22 -> 0xFFFFFFAA; lbu @0x22 -> 0x000000AA.
- Half RMW: RAM[0x30]=0x11223344; sh 0x8001 @0x32 -> w_data=0x80013344; lh @0x32 -> 0xFFFF8001; lhu @0x30 -> 0x00003344.
- Misaligned: lw @0x41, sh @0x43, size=11 @0x40 -> rsp_err=1, rdata=0, o_ram_we never asserted, rsp_valid 1 cycle after accept.
- Backpressure: hold i_rsp_ready=0 for 5 cycles after load -> rsp_valid/rdata stable, o_req_ready=0, new i_req_valid ignored; ready=1 -> IDLE next cycle.
- Reset: assert i_reset=0 in ACCESS of a store -> no o_ram_we afterwards, RAM word unchanged; outputs equal reset values; first request after release completes normally.
